// File: rtl/display_capture_ctrl.sv
// -----------------------------------------------------------------------------
// display_capture_ctrl
//
// Write-side sequencer for the time- and frequency-domain display block RAMs.
//   Time path: captures one 640-sample frame of audio into time RAM, then
//   holds it until vertical blank so the displayed frame never tears.
//   Freq path: streams FFT magnitude bins, scaled to 8 bits, into freq RAM.
// Everything runs in the ck100MHz domain.
//
// Build option:
//   CAPTURE_TRIGGER_EN  defined   -> capture starts on a rising zero crossing
//                                    (prev < 0, cur >= 0), or is forced after
//                                    TRIG_TIMEOUT samples in ARM.
//                       undefined -> free-running: first sample in ARM starts
//                                    the capture; no timeout/prev-sample logic.
//
// Ports:
//   ck100MHz     in   system clock
//   rstLow       in   synchronous active-low reset
//   sampleValid  in   strobe, sampleData valid
//   sampleData   in   signed 16-bit audio sample
//   flgVBlank    in   one-cycle pulse at start of vertical blank
//   freeze       in   level, 1 = no RAM writes at all
//   binValid     in   strobe, binMag valid
//   binMag       in   unsigned 16-bit FFT magnitude
//   binLast      in   with binValid: last bin of the FFT frame
//   enaTime      out  time RAM enable (same as weaTime)
//   weaTime      out  time RAM write enable
//   addraTime    out  time RAM address
//   dinaTime     out  time RAM data (offset binary, 0x80 = zero)
//   weaFreq      out  freq RAM write enable
//   addraFreq    out  freq RAM address
//   dinaFreq     out  freq RAM data (saturated magnitude)
//   busy         out  1 while the time FSM is in ARM or CAPTURE
//   frameDone    out  one-cycle pulse with the write of the last time sample
// -----------------------------------------------------------------------------
module display_capture_ctrl #(
    parameter int SAMPLES      = 640,
    parameter int FREQ_BINS    = 80,
    parameter int TRIG_TIMEOUT = 4800,
    parameter int MAG_SHIFT    = 8
) (
    input  logic        ck100MHz,
    input  logic        rstLow,
    input  logic        sampleValid,
    input  logic [15:0] sampleData,
    input  logic        flgVBlank,
    input  logic        freeze,
    input  logic        binValid,
    input  logic [15:0] binMag,
    input  logic        binLast,
    output logic        enaTime,
    output logic        weaTime,
    output logic [9:0]  addraTime,
    output logic [7:0]  dinaTime,
    output logic        weaFreq,
    output logic [9:0]  addraFreq,
    output logic [7:0]  dinaFreq,
    output logic        busy,
    output logic        frameDone
);

    localparam int SCNT_W = $clog2(SAMPLES);
    localparam int BCNT_W = $clog2(FREQ_BINS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t              state_q;
    logic [SCNT_W-1:0]   sample_cnt_q;
    logic [BCNT_W-1:0]   bin_cnt_q;
    logic                wea_time_q;
    logic [9:0]          addra_time_q;
    logic [7:0]          dina_time_q;
    logic                wea_freq_q;
    logic [9:0]          addra_freq_q;
    logic [7:0]          dina_freq_q;
    logic                busy_q;
    logic                frame_done_q;
    logic                trig_s;

    // Signed sample to offset binary: flip the sign bit, keep the top 8 bits.
    function automatic logic [7:0] to_offset_bin(input logic [15:0] smp);
        return {~smp[15], smp[14:8]};
    endfunction

    // Scale the magnitude down and clamp it to the 8-bit RAM range.
    function automatic logic [7:0] sat_mag(input logic [15:0] mag);
        logic [15:0] shifted;
        shifted = mag >> MAG_SHIFT;
        if (shifted > 16'd255) begin
            return 8'hFF;
        end else begin
            return shifted[7:0];
        end
    endfunction

`ifdef CAPTURE_TRIGGER_EN
    localparam int TCNT_W = $clog2(TRIG_TIMEOUT);

    logic signed [15:0] prev_q;
    logic [TCNT_W-1:0]  tmo_q;

    // Trigger decision for the current sample: zero crossing or timeout.
    always_comb begin
        trig_s = 1'b0;
        if ((prev_q < 16'sd0 && $signed(sampleData) >= 16'sd0) ||
            (tmo_q == TCNT_W'(TRIG_TIMEOUT - 1))) begin
            trig_s = 1'b1;
        end else begin
            trig_s = 1'b0;
        end
    end

    // Previous-sample register and ARM timeout counter.
    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            prev_q <= 16'sd0;
            tmo_q  <= '0;
        end else begin
            if (sampleValid) begin
                prev_q <= $signed(sampleData);
            end
            // Timeout restarts on every re-arm and after each trigger.
            if (state_q == ST_HOLD && flgVBlank && !freeze) begin
                tmo_q <= '0;
            end else if (state_q == ST_ARM && sampleValid && !freeze) begin
                tmo_q <= trig_s ? '0 : tmo_q + TCNT_W'(1);
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = (^sampleData[7:0]) ^ (TRIG_TIMEOUT > 0);

    // Free-running: any sample seen in ARM starts the frame.
    always_comb begin
        trig_s = 1'b1;
    end
`endif

    // Time FSM with registered RAM write port, busy and frameDone.
    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            wea_time_q   <= 1'b0;
            addra_time_q <= 10'd0;
            dina_time_q  <= 8'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wea_time_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!freeze) begin
                        state_q <= ST_ARM;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (freeze) begin
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b0;
                    end else if (sampleValid && trig_s) begin
                        // The triggering sample is the first one stored.
                        wea_time_q   <= 1'b1;
                        addra_time_q <= 10'd0;
                        dina_time_q  <= to_offset_bin(sampleData);
                        sample_cnt_q <= SCNT_W'(1);
                        state_q      <= ST_CAPTURE;
                        busy_q       <= 1'b1;
                    end else begin
                        busy_q       <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (freeze) begin
                        // Abandon the frame; partial data stays in RAM.
                        state_q <= ST_HOLD;
                        busy_q  <= 1'b0;
                    end else if (sampleValid) begin
                        wea_time_q   <= 1'b1;
                        addra_time_q <= 10'(sample_cnt_q);
                        dina_time_q  <= to_offset_bin(sampleData);
                        if (sample_cnt_q == SCNT_W'(SAMPLES - 1)) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_HOLD;
                            busy_q       <= 1'b0;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + SCNT_W'(1);
                            busy_q       <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A sample arriving with the blank pulse is not captured.
                    if (flgVBlank && !freeze) begin
                        state_q      <= ST_ARM;
                        sample_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end else begin
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Frequency path: registered write of scaled bins, saturating bin counter.
    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            bin_cnt_q    <= '0;
            wea_freq_q   <= 1'b0;
            addra_freq_q <= 10'd0;
            dina_freq_q  <= 8'd0;
        end else begin
            wea_freq_q <= 1'b0;
            if (binValid) begin
                if (!freeze && bin_cnt_q < BCNT_W'(FREQ_BINS)) begin
                    wea_freq_q   <= 1'b1;
                    addra_freq_q <= 10'(bin_cnt_q);
                    dina_freq_q  <= sat_mag(binMag);
                end
                // binLast clears the counter even when the bin was dropped.
                if (binLast) begin
                    bin_cnt_q <= '0;
                end else if (!freeze && bin_cnt_q < BCNT_W'(FREQ_BINS)) begin
                    bin_cnt_q <= bin_cnt_q + BCNT_W'(1);
                end
            end
        end
    end

    assign enaTime   = wea_time_q;
    assign weaTime   = wea_time_q;
    assign addraTime = addra_time_q;
    assign dinaTime  = dina_time_q;
    assign weaFreq   = wea_freq_q;
    assign addraFreq = addra_freq_q;
    assign dinaFreq  = dina_freq_q;
    assign busy      = busy_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_display_capture_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for display_capture_ctrl. Expected RAM writes are queued as
// stimulus is driven and compared when the DUT writes. A second instance with
// MAG_SHIFT=4 exercises magnitude saturation.
// -----------------------------------------------------------------------------
module tb_display_capture_ctrl;

`ifdef CAPTURE_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic        ck100MHz = 1'b0;
    logic        rstLow, sampleValid, flgVBlank, freeze, binValid, binLast;
    logic [15:0] sampleData, binMag;
    logic        enaTime, weaTime, weaFreq, busy, frameDone;
    logic [9:0]  addraTime, addraFreq;
    logic [7:0]  dinaTime, dinaFreq;
    logic        enaTime4, weaTime4, weaFreq4, busy4, frameDone4;
    logic [9:0]  addraTime4, addraFreq4;
    logic [7:0]  dinaTime4, dinaFreq4;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;

    logic [18:0] tq[$];   // {frameDone, addr, data}
    logic [17:0] fq[$];   // {addr, data}
    logic [17:0] fq4[$];

    always #5 ck100MHz = ~ck100MHz;

    display_capture_ctrl dut (
        .ck100MHz(ck100MHz), .rstLow(rstLow), .sampleValid(sampleValid),
        .sampleData(sampleData), .flgVBlank(flgVBlank), .freeze(freeze),
        .binValid(binValid), .binMag(binMag), .binLast(binLast),
        .enaTime(enaTime), .weaTime(weaTime), .addraTime(addraTime),
        .dinaTime(dinaTime), .weaFreq(weaFreq), .addraFreq(addraFreq),
        .dinaFreq(dinaFreq), .busy(busy), .frameDone(frameDone)
    );

    display_capture_ctrl #(.MAG_SHIFT(4)) dut4 (
        .ck100MHz(ck100MHz), .rstLow(rstLow), .sampleValid(sampleValid),
        .sampleData(sampleData), .flgVBlank(flgVBlank), .freeze(freeze),
        .binValid(binValid), .binMag(binMag), .binLast(binLast),
        .enaTime(enaTime4), .weaTime(weaTime4), .addraTime(addraTime4),
        .dinaTime(dinaTime4), .weaFreq(weaFreq4), .addraFreq(addraFreq4),
        .dinaFreq(dinaFreq4), .busy(busy4), .frameDone(frameDone4)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] t_exp(input logic [15:0] s);
        return {~s[15], s[14:8]};
    endfunction

    function automatic logic [7:0] f_exp(input logic [15:0] m, input int sh);
        logic [15:0] v;
        v = m >> sh;
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    // Monitor: compare every RAM write against the scoreboard queues.
    always @(negedge ck100MHz) begin
        logic [18:0] ti;
        logic [17:0] fi;
        if (frameDone) fd_cnt++;
        if (weaTime) begin
            if (tq.size() == 0) begin
                check_eq("time_unexpected_wr", {22'd0, addraTime}, 32'hFFFF);
            end else begin
                ti = tq.pop_front();
                check_eq("time_addr", {22'd0, addraTime}, {22'd0, ti[17:8]});
                check_eq("time_data", {24'd0, dinaTime}, {24'd0, ti[7:0]});
                check_eq("time_ena", {31'd0, enaTime}, 32'd1);
                check_eq("time_fd", {31'd0, frameDone}, {31'd0, ti[18]});
            end
        end else if (frameDone) begin
            check_eq("fd_stray", {31'd0, frameDone}, 32'd0);
        end
        if (weaFreq) begin
            if (fq.size() == 0) begin
                check_eq("freq_unexpected_wr", {22'd0, addraFreq}, 32'hFFFF);
            end else begin
                fi = fq.pop_front();
                check_eq("freq_addr", {22'd0, addraFreq}, {22'd0, fi[17:8]});
                check_eq("freq_data", {24'd0, dinaFreq}, {24'd0, fi[7:0]});
            end
        end
        if (weaFreq4) begin
            if (fq4.size() == 0) begin
                check_eq("freq4_unexpected_wr", {22'd0, addraFreq4}, 32'hFFFF);
            end else begin
                fi = fq4.pop_front();
                check_eq("freq4_addr", {22'd0, addraFreq4}, {22'd0, fi[17:8]});
                check_eq("freq4_data", {24'd0, dinaFreq4}, {24'd0, fi[7:0]});
            end
        end
    end

    // Drive one sample; exp_addr < 0 means no write is expected.
    task automatic send_sample(input logic [15:0] v, input int exp_addr);
        sampleData  = v;
        sampleValid = 1'b1;
        if (exp_addr >= 0 && exp_addr < 640) begin
            tq.push_back({exp_addr == 639, 10'(exp_addr), t_exp(v)});
        end
        @(negedge ck100MHz);
        sampleValid = 1'b0;
    endtask

    task automatic send_bin(input logic [15:0] m, input logic last, input int exp_addr);
        binMag   = m;
        binLast  = last;
        binValid = 1'b1;
        if (exp_addr >= 0) begin
            fq.push_back({10'(exp_addr), f_exp(m, 8)});
            fq4.push_back({10'(exp_addr), f_exp(m, 4)});
        end
        @(negedge ck100MHz);
        binValid = 1'b0;
        binLast  = 1'b0;
    endtask

    task automatic pulse_vblank();
        flgVBlank = 1'b1;
        @(negedge ck100MHz);
        flgVBlank = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_wea"},   {31'd0, weaTime}, 32'd0);
        check_eq({tag, "_ena"},   {31'd0, enaTime}, 32'd0);
        check_eq({tag, "_addr"},  {22'd0, addraTime}, 32'd0);
        check_eq({tag, "_din"},   {24'd0, dinaTime}, 32'd0);
        check_eq({tag, "_weaf"},  {31'd0, weaFreq}, 32'd0);
        check_eq({tag, "_addrf"}, {22'd0, addraFreq}, 32'd0);
        check_eq({tag, "_dinf"},  {24'd0, dinaFreq}, 32'd0);
        check_eq({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_eq({tag, "_fd"},    {31'd0, frameDone}, 32'd0);
    endtask

    initial begin
        int a;
        logic [15:0] v;
        rstLow = 1'b0; sampleValid = 1'b0; sampleData = 16'd0; flgVBlank = 1'b0;
        freeze = 1'b0; binValid = 1'b0; binMag = 16'd0; binLast = 1'b0;
        repeat (3) @(negedge ck100MHz);
        check_idle_outputs("reset");
        rstLow = 1'b1;
        repeat (2) @(negedge ck100MHz);
        check_eq("busy_after_reset", {31'd0, busy}, 32'd1);

        // Zero-crossing capture: -5, -3, then +2 and onwards.
        for (int k = 0; k < 642; k++) begin
            if (k == 0)      v = 16'hFFFB;
            else if (k == 1) v = 16'hFFFD;
            else if (k == 2) v = 16'h0002;
            else             v = 16'((k - 2) * 53 - 16000);
            a = TRIG_EN ? k - 2 : k;
            send_sample(v, a);
        end
        @(negedge ck100MHz);
        check_eq("fd_count_frame1", fd_cnt, 1);

        // HOLD: no writes until vertical blank, then busy again.
        for (int k = 0; k < 50; k++) send_sample(16'd300, -1);
        check_eq("busy_in_hold", {31'd0, busy}, 32'd0);
        pulse_vblank();
        check_eq("busy_after_vblank", {31'd0, busy}, 32'd1);

        // Constant positive input: capture forced by the timeout.
        for (int k = 0; k < 5099; k++) begin
            a = TRIG_EN ? k - 4799 : k;
            send_sample(16'd100, a);
        end
        @(negedge ck100MHz);
        check_eq("fd_count_frame2", fd_cnt, TRIG_EN ? 1 : 2);
        check_eq("busy_mid_capture", {31'd0, busy}, TRIG_EN ? 32'd1 : 32'd0);

        // Freeze abandons the capture; blank is ignored while frozen.
        freeze = 1'b1;
        @(negedge ck100MHz);
        for (int k = 0; k < 5; k++) send_sample(16'd1000, -1);
        check_eq("busy_frozen", {31'd0, busy}, 32'd0);
        pulse_vblank();
        check_eq("busy_vblank_frozen", {31'd0, busy}, 32'd0);
        freeze = 1'b0;
        @(negedge ck100MHz);
        // Re-arm with a sample coinciding with the blank: not captured.
        sampleData = 16'hFFF9; sampleValid = 1'b1; flgVBlank = 1'b1;
        @(negedge ck100MHz);
        sampleValid = 1'b0; flgVBlank = 1'b0;
        check_eq("busy_rearm", {31'd0, busy}, 32'd1);
        send_sample(16'hFFFF, TRIG_EN ? -1 : 0);
        send_sample(16'h0000, TRIG_EN ? 0 : 1);
        send_sample(16'h4000, TRIG_EN ? 1 : 2);

        // Reset with a sample in flight: no write may come out.
        sampleData = 16'h1234; sampleValid = 1'b1; rstLow = 1'b0;
        @(negedge ck100MHz);
        sampleValid = 1'b0;
        check_idle_outputs("rst_mid");
        rstLow = 1'b1;
        @(negedge ck100MHz);
        check_eq("no_wr_after_rst", {31'd0, weaTime}, 32'd0);

        // Frequency path: 100 bins, only the first 80 land.
        for (int b = 1; b <= 100; b++) begin
            send_bin(16'h1234, b == 100, (b <= 80) ? b - 1 : -1);
        end
        send_bin(16'hABCD, 1'b0, 0);
        send_bin(16'h00FF, 1'b0, 1);
        send_bin(16'hFFFF, 1'b0, 2);
        freeze = 1'b1;
        send_bin(16'h5555, 1'b0, -1);
        send_bin(16'h5555, 1'b1, -1);
        freeze = 1'b0;
        send_bin(16'h0100, 1'b0, 0);
        repeat (3) @(negedge ck100MHz);

        check_eq("time_queue_drained", tq.size(), 0);
        check_eq("freq_queue_drained", fq.size(), 0);
        check_eq("freq4_queue_drained", fq4.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
